// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
// The master side issues operations and MTHI/MTLO writes; the slave side owns HI/LO.
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_lo_wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start, op, operand_a, operand_b, hi_we, lo_we, hi_lo_wdata,
        input  busy, done, div_by_zero, hi_out, lo_out
    );

    modport slave (
        input  start, op, operand_a, operand_b, hi_we, lo_we, hi_lo_wdata,
        output busy, done, div_by_zero, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO registers, fixed 33-cycle latency.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU complete at once as no-ops.
module muldiv_unit (
    input  logic        clock,
    input  logic        reset,
    muldiv_unit_if.slave md_io
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mb_q, mb_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

`ifdef MULDIV_DIV_EN
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic        bz_q, bz_d;
    logic        run_req;
    logic [32:0] div_shift;
    logic [31:0] div_diff;
    logic [63:0] div_step;
    assign run_req = md_io.start;
`else
    logic        stub_q, stub_d;
    logic        run_req;
    assign run_req = md_io.start & ~md_io.op[1];
`endif

    logic        in_signed;
    logic        in_sa, in_sb;
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [63:0] mul_res;
    logic [31:0] fix_hi, fix_lo;

    // Signed ops are those with op[0] clear (MULT, DIV).
    assign in_signed = ~md_io.op[0];
    assign in_sa     = in_signed & md_io.operand_a[31];
    assign in_sb     = in_signed & md_io.operand_b[31];

    // Accumulator layout: multiply keeps {partial product, multiplier}, divide {remainder, quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? mb_q : 32'd0)};
        mul_step = {mul_sum, acc_q[31:1]};
        mul_res  = (sa_q ^ sb_q) ? (64'd0 - acc_q) : acc_q;
    end

`ifdef MULDIV_DIV_EN
    always_comb begin
        div_shift = {acc_q[63:32], acc_q[31]};
        div_diff  = div_shift[31:0] - mb_q;
        if (div_shift >= {1'b0, mb_q}) begin
            div_step = {div_diff, acc_q[30:0], 1'b1};
        end else begin
            div_step = {div_shift[31:0], acc_q[30:0], 1'b0};
        end
    end
`endif

    always_comb begin
        fix_hi = mul_res[63:32];
        fix_lo = mul_res[31:0];
`ifdef MULDIV_DIV_EN
        if (op_q[1]) begin
            if (bz_q) begin
                fix_hi = a_q;
                fix_lo = 32'hFFFF_FFFF;
            end else begin
                fix_hi = sa_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
                fix_lo = (sa_q ^ sb_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mb_d    = mb_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
`ifdef MULDIV_DIV_EN
        op_d    = op_q;
        a_d     = a_q;
        bz_d    = bz_q;
`else
        // A DIV/DIVU request completes one cycle later without touching HI/LO.
        stub_d  = md_io.start & md_io.op[1] & (state_q == StIdle);
        done_d  = stub_q;
`endif
        case (state_q)
            StIdle: begin
                if (md_io.hi_we) hi_d = md_io.hi_lo_wdata;
                if (md_io.lo_we) lo_d = md_io.hi_lo_wdata;
                if (run_req) begin
                    sa_d    = in_sa;
                    sb_d    = in_sb;
                    acc_d   = {32'd0, (in_sa ? (32'd0 - md_io.operand_a) : md_io.operand_a)};
                    mb_d    = in_sb ? (32'd0 - md_io.operand_b) : md_io.operand_b;
                    cnt_d   = 5'd31;
                    state_d = StRun;
`ifdef MULDIV_DIV_EN
                    op_d    = md_io.op;
                    a_d     = md_io.operand_a;
                    bz_d    = (md_io.operand_b == 32'd0);
`endif
                end
            end
            StRun: begin
`ifdef MULDIV_DIV_EN
                acc_d = op_q[1] ? div_step : mul_step;
`else
                acc_d = mul_step;
`endif
                if (cnt_q == 5'd0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StFix: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
                dbz_d   = op_q[1] & bz_q;
`endif
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            mb_q    <= 32'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            bz_q    <= 1'b0;
`else
            stub_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mb_q    <= mb_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef MULDIV_DIV_EN
            op_q    <= op_d;
            a_q     <= a_d;
            bz_q    <= bz_d;
`else
            stub_q  <= stub_d;
`endif
        end
    end

    assign md_io.busy        = (state_q != StIdle);
    assign md_io.done        = done_q;
    assign md_io.div_by_zero = dbz_q;
    assign md_io.hi_out      = hi_q;
    assign md_io.lo_out      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random operations
// against an arithmetic reference model; adapts to the MULDIV_DIV_EN build option.
module tb_muldiv_unit;

    logic clock;
    logic reset;
    int   n_pass;
    int   n_total;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    muldiv_unit_if bus_if ();

    muldiv_unit dut (
        .clock (clock),
        .reset (reset),
        .md_io (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef MULDIV_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: returns {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: p = 64'(sa * sb);
            2'b01: p = 64'(a) * 64'(b);
            default: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end else begin
                    p = {a % b, a / b};
                end
            end
        endcase
        return p;
    endfunction

    // Issue start at the next posedge; returns at the negedge just after it.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus_if.start     = 1'b1;
        bus_if.op        = op;
        bus_if.operand_a = a;
        bus_if.operand_b = b;
        @(negedge clock);
        bus_if.start     = 1'b0;
        bus_if.op        = 2'($urandom);
        bus_if.operand_a = $urandom;
        bus_if.operand_b = $urandom;
    endtask

    task automatic wait_done(inout int lat);
        while (!bus_if.done && lat < 40) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] exp;
        int          lat;
        int          exp_lat;
        logic        exp_dbz;
        exp     = model(op, a, b);
        exp_lat = (op[1] && !DivEn) ? 1 : 33;
        exp_dbz = op[1] && DivEn && (b == 32'd0);
        if (exp_lat == 33) begin
            hi_m = exp[63:32];
            lo_m = exp[31:0];
        end
        launch(op, a, b);
        chk({tag, " busy0"}, bus_if.busy, (exp_lat == 33));
        lat = 0;
        wait_done(lat);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy"}, bus_if.busy, 0);
        chk({tag, " dbz"}, bus_if.div_by_zero, exp_dbz);
        chk({tag, " hi"}, bus_if.hi_out, hi_m);
        chk({tag, " lo"}, bus_if.lo_out, lo_m);
        @(negedge clock);
        chk({tag, " pulse"}, bus_if.done, 0);
    endtask

    initial begin
        int          lat;
        logic        seen;
        logic [31:0] w;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        n_pass  = 0;
        n_total = 0;
        bus_if.start       = 1'b0;
        bus_if.op          = 2'd0;
        bus_if.operand_a   = 32'd0;
        bus_if.operand_b   = 32'd0;
        bus_if.hi_we       = 1'b0;
        bus_if.lo_we       = 1'b0;
        bus_if.hi_lo_wdata = 32'd0;

        // Reset overrides concurrent start and HI/LO writes.
        reset = 1'b1;
        bus_if.start = 1'b1;
        bus_if.hi_we = 1'b1;
        bus_if.lo_we = 1'b1;
        bus_if.hi_lo_wdata = 32'hA5A5_A5A5;
        repeat (2) @(negedge clock);
        bus_if.start = 1'b0;
        bus_if.hi_we = 1'b0;
        bus_if.lo_we = 1'b0;
        reset = 1'b0;
        hi_m = 32'd0;
        lo_m = 32'd0;
        chk("rst busy", bus_if.busy, 0);
        chk("rst done", bus_if.done, 0);
        chk("rst dbz", bus_if.div_by_zero, 0);
        chk("rst hi", bus_if.hi_out, 0);
        chk("rst lo", bus_if.lo_out, 0);

        // MTLO in idle.
        bus_if.lo_we = 1'b1;
        bus_if.hi_lo_wdata = 32'hDEAD_BEEF;
        @(negedge clock);
        bus_if.lo_we = 1'b0;
        lo_m = 32'hDEAD_BEEF;
        chk("mtlo lo", bus_if.lo_out, lo_m);
        chk("mtlo hi", bus_if.hi_out, hi_m);
        bus_if.hi_we = 1'b1;
        bus_if.hi_lo_wdata = 32'h0BAD_F00D;
        @(negedge clock);
        bus_if.hi_we = 1'b0;
        hi_m = 32'h0BAD_F00D;
        chk("mthi hi", bus_if.hi_out, hi_m);

        run_op("mult -3*5", 2'b00, 32'hFFFF_FFFD, 32'd5);
        run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu 100/0", 2'b11, 32'd100, 32'd0);
        run_op("div -7/0", 2'b10, 32'hFFFF_FFF9, 32'd0);
        run_op("div 8/2", 2'b10, 32'd8, 32'd2);

        // Start and MTHI while busy are ignored.
        launch(2'b01, 32'd6, 32'd7);
        repeat (4) @(negedge clock);
        bus_if.start = 1'b1;
        bus_if.op = 2'b11;
        bus_if.operand_a = 32'd9;
        bus_if.operand_b = 32'd3;
        bus_if.hi_we = 1'b1;
        bus_if.hi_lo_wdata = 32'h1234_5678;
        @(negedge clock);
        bus_if.start = 1'b0;
        bus_if.hi_we = 1'b0;
        chk("busy ign hi", bus_if.hi_out, hi_m);
        lat = 5;
        wait_done(lat);
        hi_m = 32'd0;
        lo_m = 32'd42;
        chk("busy ign lat", lat, 33);
        chk("busy ign hi2", bus_if.hi_out, hi_m);
        chk("busy ign lo", bus_if.lo_out, lo_m);
        repeat (5) @(negedge clock);
        chk("busy ign no2nd", bus_if.busy, 0);

        // Same-edge start and MTHI/MTLO: write lands, result overwrites it.
        w = $urandom;
        ra = $urandom;
        rb = $urandom;
        bus_if.hi_we = 1'b1;
        bus_if.lo_we = 1'b1;
        bus_if.hi_lo_wdata = w;
        launch(2'b01, ra, rb);
        bus_if.hi_we = 1'b0;
        bus_if.lo_we = 1'b0;
        chk("same edge hi", bus_if.hi_out, w);
        chk("same edge lo", bus_if.lo_out, w);
        lat = 0;
        wait_done(lat);
        chk("same edge lat", lat, 33);
        chk("same edge res", {bus_if.hi_out, bus_if.lo_out}, model(2'b01, ra, rb));
        hi_m = bus_if.hi_out;
        lo_m = bus_if.lo_out;

        // Reset mid-operation aborts with no done.
        launch(2'b00, 32'h1234_5678, 32'h0000_0100);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        bus_if.start = 1'b1;
        bus_if.lo_we = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bus_if.start = 1'b0;
        bus_if.lo_we = 1'b0;
        hi_m = 32'd0;
        lo_m = 32'd0;
        chk("abort busy", bus_if.busy, 0);
        chk("abort hi", bus_if.hi_out, 0);
        chk("abort lo", bus_if.lo_out, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus_if.done) seen = 1'b1;
        end
        chk("abort no done", seen, 0);
        run_op("mult 2*3", 2'b00, 32'd2, 32'd3);

        // Random mix.
        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb % 16;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            run_op($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have clock  input  1  clock; all state changes on posedge clock.
REQ-002 The block SHALL have reset  input  1  synchronous, active-high reset.
REQ-003 The block SHALL have start  input  1  request to begin an operation, sampled on posedge clock.
REQ-004 The block SHALL have op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 The block SHALL have operand_a  input  32  rs value from the register file data_out_1.
REQ-006 The block SHALL have operand_b  input  32  rt value from the register file data_out_2.
REQ-007 The block SHALL have hi_we and lo_we  input  1 each  MTHI/MTLO write strobes.
REQ-008 The block SHALL have hi_lo_wdata  input  32  MTHI/MTLO write data.
REQ-009 The block SHALL have busy  output  1  high while an operation is in progress.
REQ-010 The block SHALL have done  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have div_by_zero  output  1  one-cycle flag coincident with done.
REQ-012 The block SHALL have hi_out and lo_out  output  32 each  registered HI and LO contents.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, FIX; only IDLE SHALL accept start.
REQ-014 On start in IDLE, the block SHALL latch op, operand_a and operand_b, take magnitudes for signed ops, load a 5-bit counter with 31, and go to RUN; busy SHALL rise after that edge.
REQ-015 RUN SHALL perform one iteration per cycle: shift-add for multiply, restoring shift-subtract for divide; after the counter=0 iteration it SHALL go to FIX.
REQ-016 FIX SHALL apply sign fixup, write HI/LO, pulse done for one cycle, drop busy, and return to IDLE.
REQ-017 Latency SHALL be fixed: if start is sampled at edge E0, done and the new hi_out/lo_out SHALL be visible after edge E33.
REQ-018 Multiply SHALL write HI:LO = the 64-bit product; MULT SHALL be signed, MULTU unsigned.
REQ-019 Divide SHALL write LO = quotient and HI = remainder.
REQ-020 Signed divide SHALL truncate toward zero: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-021 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-022 Divide with operand_b=0 SHALL take the normal latency and yield LO=0xFFFFFFFF and HI=operand_a, with div_by_zero=1 alongside done.
REQ-023 start while busy SHALL be ignored.
REQ-024 hi_we/lo_we while busy SHALL be ignored.
REQ-025 In IDLE, hi_we/lo_we SHALL write hi_lo_wdata to HI/LO at the edge.
REQ-026 If start and hi_we/lo_we occur at the same edge in IDLE, both SHALL take effect, and the operation result SHALL overwrite HI/LO at completion.
REQ-027 Operands SHALL be sampled only at the accepting edge; later input changes SHALL not affect the result.

Reset
REQ-028 While reset is high at posedge clock, the FSM SHALL go to IDLE; busy, done and div_by_zero SHALL be 0; hi_out and lo_out SHALL be 0x00000000; the counter SHALL be 0.
REQ-029 Reset SHALL override start and hi_we/lo_we in the same cycle.
REQ-030 Reset mid-operation SHALL abort the operation with no done pulse.

Configuration
REQ-031 With MULDIV_DIV_EN defined, DIV/DIVU SHALL be implemented as specified above.
REQ-032 Without MULDIV_DIV_EN, start with op[1]=1 SHALL pulse done one cycle after the accepting edge, with busy never asserted, HI/LO unchanged and div_by_zero=0; no divider logic SHALL be synthesized.

Verification
REQ-033 MULT a=0xFFFFFFFD (-3), b=5 -> done 33 cycles after start; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-034 MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-035 DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=100, b=0 -> LO=0xFFFFFFFF, HI=0x00000064, div_by_zero=1 with done.
REQ-036 MULTU 6*7 started, second start (DIVU 9/3) and hi_we with data 0x12345678 issued at cycle 5 -> both ignored; HI=0, LO=42 after 33 cycles.
REQ-037 Reset asserted 10 cycles into MULT -> busy=0, HI=LO=0, and no done pulse; a new MULT 2*3 then yields LO=6.
REQ-038 In IDLE, lo_we with data 0xDEADBEEF -> lo_out=0xDEADBEEF next cycle with HI unchanged; build without MULDIV_DIV_EN, DIV 8/2 -> done after 1 cycle, HI/LO unchanged.
